// File: rtl/pipeline_pkg.sv
// Shared Fetch->Decode pipeline types: the queued entry layout and its bubble value.
package pipeline_pkg;

  localparam int PKG_INSTR_WIDTH = 32;
  localparam int PKG_PC_WIDTH    = 32;

  typedef struct packed {
    logic [PKG_INSTR_WIDTH-1:0] instruction;
    logic [PKG_PC_WIDTH-1:0]    pc;
    logic                       take_jb;
  } FetchEntry_t;

  localparam FetchEntry_t NOP_ENTRY = '0;

  // Queue depth must be a power of two so the pointers wrap on their own.
  function automatic bit depthIsLegal(input int depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for an in-order queue with reset > flush > push/pop priority.
module sync_fifo_ctrl #(
  parameter  int DEPTH     = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_req_i,
  input  logic                 pop_req_i,
  output logic                 wr_en_o,
  output logic [PTR_WIDTH-1:0] wr_ptr_o,
  output logic [PTR_WIDTH-1:0] rd_ptr_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push, pop;

  // Full/empty come from the registered count only, so ready never depends on the consumer.
  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_req_i & ~full_o;
  assign pop     = pop_req_i & ~empty_o;
  assign wr_en_o = push & ~flush_i;

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

  // Next-state: flush empties the queue and swallows any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_WIDTH'(DEPTH));
`endif

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry in-order Fetch->Decode queue with valid/ready on both sides and flush.
module fetch_decode_queue
  import pipeline_pkg::*;
#(
  parameter  int INSTR_WIDTH = PKG_INSTR_WIDTH,
  parameter  int PC_WIDTH    = PKG_PC_WIDTH,
  parameter  int DEPTH       = 4,
  localparam int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   iFlushD,
  input  logic                   iValidF,
  input  logic [INSTR_WIDTH-1:0] iInstructionF,
  input  logic [PC_WIDTH-1:0]    iPCF,
  input  logic                   iTakeJBF,
  output logic                   oReadyF,
  output logic                   oValidD,
  input  logic                   iReadyD,
  output logic [INSTR_WIDTH-1:0] oInstructionD,
  output logic [PC_WIDTH-1:0]    oPCD,
  output logic                   oTakeJBD,
  output logic [CNT_WIDTH-1:0]   oCount
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  if (!depthIsLegal(DEPTH)) begin : gIllegalDepth
    $error("fetch_decode_queue: DEPTH must be a power of two in 2..16");
  end
  if ((INSTR_WIDTH != PKG_INSTR_WIDTH) || (PC_WIDTH != PKG_PC_WIDTH)) begin : gWidthMismatch
    $error("fetch_decode_queue: widths must match the pipeline_pkg entry layout");
  end

  FetchEntry_t          mem_q [DEPTH];
  FetchEntry_t          fetchEntry;
  FetchEntry_t          headEntry;
  logic                 wrEn;
  logic [PTR_WIDTH-1:0] wrPtr, rdPtr;
  logic                 full, empty;

  sync_fifo_ctrl #(.DEPTH(DEPTH)) uCtrl (
    .clk_i      (iClk),
    .rst_ni     (iRstN),
    .flush_i    (iFlushD),
    .push_req_i (iValidF),
    .pop_req_i  (iReadyD),
    .wr_en_o    (wrEn),
    .wr_ptr_o   (wrPtr),
    .rd_ptr_o   (rdPtr),
    .count_o    (oCount),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign fetchEntry = {iInstructionF, iPCF, iTakeJBF};

  // Storage: cleared on reset, written at the write pointer on an accepted push.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_ENTRY;
    end else if (wrEn) begin
      mem_q[wrPtr] <= fetchEntry;
    end
  end

  // An empty queue presents a NOP bubble rather than stale storage.
  assign headEntry     = empty ? NOP_ENTRY : mem_q[rdPtr];
  assign oReadyF       = ~full;
  assign oValidD       = ~empty;
  assign oInstructionD = headEntry.instruction;
  assign oPCD          = headEntry.pc;
  assign oTakeJBD      = headEntry.take_jb;

`ifndef SYNTHESIS
  assert property (@(posedge iClk) (iRstN && !iFlushD && oValidD && !iReadyD)
                   |=> $stable({oInstructionD, oPCD, oTakeJBD}));
`endif

endmodule
